// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters.
//   Port 0 is the execute stage, port 1 the branch/compare unit.
//   Requests are arbitrated round-robin, one operation is in flight at a time,
//   and each result comes back on the requesting port's response handshake.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   reqN_valid/ready/a/b/op (N=0,1)     request handshake and payload
//   rspN_valid/ready/data/zero/err      response handshake and payload
//   alu_a, alu_b, alu_op, alu_res       ALU operand/opcode drive and result
module alu_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res
);

  localparam int unsigned CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prio_q, prio_d;   // 1: req1 has priority on a tie
  logic                id_q, id_d;       // port being served
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;
  logic [1:0]          vld_q, vld_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;

  logic                gnt_vld_c, gnt_id_c, rsp_hs_c;
  logic [DATA_W-1:0]   sel_a_c, sel_b_c;
  logic [OP_W-1:0]     sel_op_c;

  // Round-robin grant: a lone requester wins, a tie goes to prio_q
  always_comb begin
    gnt_vld_c = req0_valid | req1_valid;
    gnt_id_c  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id_c = prio_q;
    end else if (req1_valid) begin
      gnt_id_c = 1'b1;
    end
    sel_a_c  = gnt_id_c ? req1_a  : req0_a;
    sel_b_c  = gnt_id_c ? req1_b  : req0_b;
    sel_op_c = gnt_id_c ? req1_op : req0_op;
  end

  assign req0_ready = (state_q == IDLE) && gnt_vld_c && !gnt_id_c;
  assign req1_ready = (state_q == IDLE) && gnt_vld_c &&  gnt_id_c;
  assign rsp_hs_c   = (vld_q[0] & rsp0_ready) | (vld_q[1] & rsp1_ready);

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prio_d   = prio_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    data_d   = data_q;
    zero_d   = zero_q;
    err_d    = err_q;
    vld_d    = vld_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          id_d = gnt_id_c;
          a_d  = sel_a_c;
          b_d  = sel_b_c;
          op_d = sel_op_c;
          if (sel_op_c > OP_CMP) begin
            // Illegal opcode: answer immediately, ALU drive untouched
            data_d  = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
            vld_d   = gnt_id_c ? 2'b10 : 2'b01;
            state_d = RESP;
          end else begin
            alu_a_d  = sel_a_c;
            alu_b_d  = sel_b_c;
            alu_op_d = sel_op_c;
            cnt_d    = CNT_W'(ALU_LAT);
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = alu_res;
          zero_d  = (op_q == OP_CMP) && (a_q == b_q);
          err_d   = 1'b0;
          vld_d   = id_q ? 2'b10 : 2'b01;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_hs_c) begin
          vld_d   = 2'b00;
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 2'b00;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign rsp0_valid = vld_q[0];
  assign rsp1_valid = vld_q[1];
  assign rsp0_data  = data_q;
  assign rsp1_data  = data_q;
  assign rsp0_zero  = zero_q;
  assign rsp1_zero  = zero_q;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed table, corner sequences, random ops
// against a reference model of arbitration order and ALU results.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [OW-1:0] req0_op = '0, req1_op = '0;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [OW-1:0] alu_op;

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  int prio_m = 0;          // model: port that wins a tie
  logic [OW-1:0] last_op = '0; // model: opcode last issued to the ALU

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res)
  );

  // ALU arithmetic; compare passes operand a through
  function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a | b;
      4'd3: return a & b;
      4'd4: return a;
      default: return '0;
    endcase
  endfunction

  // One-register ALU
  always @(posedge clk) alu_res <= alu_fn(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk)
    if (mon_en && rst_n && (req0_ready || req1_ready))
      check("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);

  function automatic logic any_out();
    return req0_ready | req1_ready | rsp0_valid | rsp1_valid | (|rsp0_data) | (|rsp1_data) |
           rsp0_zero | rsp1_zero | rsp0_err | rsp1_err | (|alu_a) | (|alu_b) | (|alu_op);
  endfunction

  // Waits for a grant, completes request and response handshakes.
  task automatic serve(input int hold, output int who, output logic [DW-1:0] d,
                       output logic z, output logic e, output int lat);
    int t = 0;
    logic rv;
    #1;
    while (!(req0_ready || req1_ready) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    check("grant_seen", 64'(req0_ready | req1_ready), 64'd1);
    who = req1_ready ? 1 : 0;
    @(posedge clk); #1;
    if (who == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      rv = (who == 1) ? rsp1_valid : rsp0_valid;
    end while (!rv && lat < 20);
    check("rsp_seen", 64'(rv), 64'd1);
    check("rsp_other_quiet", 64'((who == 1) ? rsp0_valid : rsp1_valid), 64'd0);
    d = (who == 1) ? rsp1_data : rsp0_data;
    z = (who == 1) ? rsp1_zero : rsp0_zero;
    e = (who == 1) ? rsp1_err  : rsp0_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'((who == 1) ? rsp1_valid : rsp0_valid), 64'd1);
      check("hold_data", 64'((who == 1) ? rsp1_data : rsp0_data), 64'(d));
      check("hold_flags", 64'({(who == 1) ? rsp1_zero : rsp0_zero, (who == 1) ? rsp1_err : rsp0_err}), 64'({z, e}));
      check("hold_no_accept", 64'(req0_ready | req1_ready), 64'd0);
    end
    if (who == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("rsp_dropped", 64'(rsp0_valid | rsp1_valid), 64'd0);
    @(negedge clk);
  endtask

  task automatic set_req(input int port, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    if (port == 1) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
  endtask

  // Compares a served response with the model and updates model state
  task automatic judge(input string tag, input int exp_who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [OW-1:0] op, input int who, input logic [DW-1:0] d, input logic z,
                       input logic e, input int lat);
    logic ill;
    ill = (op > 4'd4);
    check({tag, "_who"}, 64'(who), 64'(exp_who));
    check({tag, "_data"}, 64'(d), ill ? 64'd0 : 64'(alu_fn(a, b, op)));
    check({tag, "_zero"}, 64'(z), 64'((op == 4'd4) && (a == b)));
    check({tag, "_err"}, 64'(e), 64'(ill));
    check({tag, "_lat"}, 64'(lat), ill ? 64'd1 : 64'd3);
    if (!ill) last_op = op;
    prio_m = 1 - exp_who;
  endtask

  typedef struct {
    int            port;
    logic [DW-1:0] a, b;
    logic [OW-1:0] op;
    logic [DW-1:0] data;
    logic          zero, err;
    int            lat;
    int            hold;
  } vec_t;

  vec_t vt[8];
  int who, lat;
  logic [DW-1:0] d;
  logic z, e;

  initial begin
    vt[0] = '{0, 32'd5,        32'd7,        4'd0, 32'd12,         1'b0, 1'b0, 3, 0};
    vt[1] = '{0, 32'd3,        32'd5,        4'd1, 32'hFFFF_FFFE,  1'b0, 1'b0, 3, 1};
    vt[2] = '{1, 32'h55,       32'h55,       4'd4, 32'h55,         1'b1, 1'b0, 3, 0};
    vt[3] = '{1, 32'h55,       32'h54,       4'd4, 32'h55,         1'b0, 1'b0, 3, 2};
    vt[4] = '{0, 32'hFFFF_FFFF,32'd2,        4'd0, 32'd1,          1'b0, 1'b0, 3, 0};
    vt[5] = '{1, 32'hFF00,     32'h0FF0,     4'd3, 32'h0F00,       1'b0, 1'b0, 3, 0};
    vt[6] = '{0, 32'h1234,     32'h1234,     4'd15,32'd0,          1'b0, 1'b1, 1, 3};
    vt[7] = '{1, 32'hF0,       32'h0F,       4'd2, 32'hFF,         1'b0, 1'b0, 3, 0};

    // Reset and first operation
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_quiet", 64'(any_out()), 64'd0);
    mon_en = 1'b1;

    // Reset during WAIT drops the operation
    set_req(0, 32'd9, 32'd1, 4'd1);
    #1;
    check("pre_rst_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1; req0_valid = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 64'(any_out()), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 64'(rsp0_valid | rsp1_valid), 64'd0);
    end
    prio_m = 0; last_op = '0;

    // Fairness: both ports continuously valid -> 0, 1, 0
    for (int k = 0; k < 3; k++) begin
      if (!req0_valid) set_req(0, 32'd1, 32'd1, 4'd0);
      if (!req1_valid) set_req(1, 32'hF0, 32'h0F, 4'd2);
      serve(0, who, d, z, e, lat);
      check("fair_order", 64'(who), 64'(k % 2));
      check("fair_data", 64'(d), (k % 2 == 1) ? 64'hFF : 64'd2);
      prio_m = 1 - who;
    end
    req1_valid = 1'b0;
    last_op = 4'd0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      set_req(vt[i].port, vt[i].a, vt[i].b, vt[i].op);
      serve(vt[i].hold, who, d, z, e, lat);
      check("tbl_who", 64'(who), 64'(vt[i].port));
      check("tbl_data", 64'(d), 64'(vt[i].data));
      check("tbl_zero", 64'(z), 64'(vt[i].zero));
      check("tbl_err", 64'(e), 64'(vt[i].err));
      check("tbl_lat", 64'(lat), 64'(vt[i].lat));
      if (!vt[i].err) last_op = vt[i].op;
      check("tbl_alu_op", 64'(alu_op), 64'(last_op));
      prio_m = 1 - vt[i].port;
    end

    // Illegal op with backpressure while req1 waits (req1 served last -> req0 wins)
    set_req(0, 32'h77, 32'h11, 4'd7);
    set_req(1, 32'h20, 32'h22, 4'd1);
    serve(5, who, d, z, e, lat);
    judge("bp", 0, 32'h77, 32'h11, 4'd7, who, d, z, e, lat);
    check("bp_alu_op_kept", 64'(alu_op), 64'(last_op));
    serve(0, who, d, z, e, lat);
    judge("bp_next", 1, 32'h20, 32'h22, 4'd1, who, d, z, e, lat);

    // Random traffic against the model
    for (int it = 0; it < 60; it++) begin
      logic [DW-1:0] ra[2], rb[2];
      logic [OW-1:0] rop[2];
      int mask, ew;
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        ra[p] = $urandom;
        rb[p] = ($urandom_range(0, 3) == 0) ? ra[p] : 32'($urandom);
        rop[p] = OW'($urandom_range(0, 7));
        if (mask[p]) set_req(p, ra[p], rb[p], rop[p]);
      end
      while (mask != 0) begin
        ew = (mask == 3) ? prio_m : ((mask == 1) ? 0 : 1);
        serve($urandom_range(0, 3), who, d, z, e, lat);
        judge("rnd", ew, ra[ew], rb[ew], rop[ew], who, d, z, e, lat);
        check("rnd_alu_op", 64'(alu_op), 64'(last_op));
        mask = mask & ~(1 << ew);
      end
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single registered ALU between two requesters: port 0 is the execute stage and port 1 is the branch/compare unit. Requests arrive on valid/ready handshakes and are arbitrated round-robin. The block issues one operation at a time to the ALU, waits out the ALU register latency, then returns the result on a per-port response handshake. It sits between the control/execute logic and the ALU instance, and is the only driver of the ALU operand and opcode inputs.

Parameters:
DATA_W, 32, operand/result width
OP_W, 4, opcode width (ALU encoding: 0 add, 1 sub, 2 or, 3 and, 4 compare; 5..15 illegal)
ALU_LAT, 1, clock edges from ALU input change to valid alu_res (minimum 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
reqN_valid  in  1  request valid, N = 0,1
reqN_ready  out  1  request accepted this cycle
reqN_a, reqN_b  in  DATA_W  operands
reqN_op  in  OP_W  opcode
rspN_valid  out  1  response valid
rspN_ready  in  1  response consumed
rspN_data  out  DATA_W  result
rspN_zero  out  1  compare result (a==b); 0 for non-compare ops
rspN_err  out  1  illegal opcode flag
alu_a, alu_b  out  DATA_W  to ALU
alu_op  out  OP_W  to ALU
alu_res  in  DATA_W  from ALU

Behaviour:
- Reset is asynchronous on rst_n low: state IDLE, all outputs 0, alu_a/alu_b/alu_op 0, round-robin pointer gives req0 priority. Reset mid-operation aborts the operation and drops any pending response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, grant goes to the one not served last (req0 after reset).
  - reqN_ready = (state==IDLE) && (grant==N). It is combinational and never high for both ports.
  - On handshake: latch a, b, op and grant id.
  - Legal op: drive alu_* from the latched registers, load cnt=ALU_LAT, go to WAIT.
  - Illegal op (>4): do not touch alu_*, set data=0 and err=1, go directly to RESP.
- WAIT:
  - alu_* are held stable.
  - If cnt==0: capture alu_res into the data register and go to RESP. Otherwise decrement cnt.
  - zero is computed locally as (latched a == latched b) when op==4, else 0. The ALU does not export its flag.
- RESP:
  - rspN_valid is high for the granted port only. data, zero and err are held stable until rspN_ready.
  - On handshake: go to IDLE and set the pointer so the other port has priority.
  - The response handshake and a new request acceptance never occur in the same cycle.
- Latency (ALU_LAT=1): handshake in cycle C0, rsp valid in C0+3. Illegal op: rsp valid in C0+1.
- Throughput: one operation in flight. Minimum 4 cycles per legal op with rspN_ready tied high.
- alu_* keep their last issued values while in IDLE/RESP; there is no toggling between ops.
- Arithmetic is performed by the ALU, modulo 2^DATA_W. The arbiter does no width extension.
- reqN_valid dropping while not granted is allowed; no request is lost once it has been accepted.
- rspN_ready high while rspN_valid is low is ignored.

Test Plan:
- Reset: rst_n low for 3 cycles mid-stream → all outputs 0 immediately (asynchronous). After release, the first simultaneous request grants req0.
- Single add: req0 op=0 a=5 b=7, handshake in C0 → alu_op=0 from C1, rsp0_valid=1 in C0+3 with data=12, zero=0, err=0. Sub 3-5 → data=0xFFFFFFFE.
- Fairness: both ports continuously valid (req0 add 1+1, req1 or 0xF0|0x0F) → grants alternate req0, req1, req0. Responses are 2 and 0xFF on the matching ports only. reqN_ready is never high for both ports.
- Compare: req1 op=4 a=b=0x55 → rsp1_data=0x55, zero=1. With a=0x55, b=0x54 → zero=0.
- Illegal op and backpressure: req0 op=7 → rsp0_valid in C0+1 with err=1, data=0, and alu_op unchanged. Holding rsp0_ready low for 5 cycles → outputs stable, req1_ready held 0 until the handshake.
- Reset mid-WAIT: assert rst_n low during WAIT → no response is emitted, and the next request completes normally.
